// File: rtl/pkt_stream_if.sv
// Word stream carrying framed packets: source asserts out_wr for one cycle per word,
// sink throttles with out_rdy, and the source only writes after a cycle with out_rdy high.
interface pkt_stream_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8
);
    logic                  out_wr;
    logic [CTRL_WIDTH-1:0] out_ctrl;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_rdy;

    modport master (output out_wr, output out_ctrl, output out_data, input out_rdy);
    modport slave  (input out_wr, input out_ctrl, input out_data, output out_rdy);
endinterface

// File: rtl/pkt_stream_generator.sv
// Configurable burst source of framed packets (SOP header, body, EOP); PKT_GEN_CHECKSUM_EN puts an XOR checksum in the EOP word.
// Latency: start to first out_wr is 2 cycles; every word is registered one cycle after it is accepted.
// Backpressure: with out_rdy low nothing is written and the FSM holds, so no word is lost or repeated.
module pkt_stream_generator #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int GAP_WIDTH  = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [LEN_WIDTH-1:0] cfg_len,
    input  logic [CNT_WIDTH-1:0] cfg_num_pkts,
    input  logic [GAP_WIDTH-1:0] cfg_gap,
    input  logic [1:0]           cfg_mode,
    input  logic [31:0]          cfg_seed,
    pkt_stream_if.master         strm,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] pkt_count
);
    localparam int                    REPS      = DATA_WIDTH / 32;
    localparam logic [CTRL_WIDTH-1:0] CTRL_SOP  = CTRL_WIDTH'(8'h01);
    localparam logic [CTRL_WIDTH-1:0] CTRL_EOP  = CTRL_WIDTH'(8'h80);
    localparam logic [31:0]           LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_BODY, S_GAP, S_DONE} state_t;
    state_t state, state_nxt;

    logic [LEN_WIDTH-1:0]  len_q, word_k, k_minus1;
    logic [CNT_WIDTH-1:0]  num_q, pkt_count_inc;
    logic [GAP_WIDTH-1:0]  gap_q, gap_cnt;
    logic [1:0]            mode_q;
    logic [31:0]           seed_q, lfsr, lfsr_nxt;
    logic [DATA_WIDTH-1:0] body_cnt, hdr_data, body_data, word_data;
    logic [CTRL_WIDTH-1:0] word_ctrl;
    logic                  stop_seen, stop_any, last_word, run_full;
    logic                  emit_hdr, emit_body, emit_any, adv_payload;
    int                    walk_pos;

    assign stop_any      = stop_seen | stop;
    assign last_word     = (word_k == len_q - LEN_WIDTH'(1));
    assign k_minus1      = word_k - LEN_WIDTH'(1);
    assign pkt_count_inc = pkt_count + CNT_WIDTH'(1);
    assign run_full      = (num_q != '0) && (pkt_count_inc == num_q);
    assign emit_hdr      = (state == S_HDR) && strm.out_rdy;
    assign emit_body     = (state == S_BODY) && strm.out_rdy;
    assign emit_any      = emit_hdr | emit_body;
    assign lfsr_nxt      = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
    assign busy          = (state == S_HDR) || (state == S_BODY) || (state == S_GAP);
    assign done          = (state == S_DONE);

`ifdef PKT_GEN_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum;
    // The EOP slot carries the checksum, so the payload generators skip it.
    assign adv_payload = emit_body && !last_word;
`else
    assign adv_payload = emit_body;
`endif

    always_comb begin
        hdr_data        = '0;
        hdr_data[31:0]  = 32'(pkt_count);
        hdr_data[47:32] = 16'(len_q);
        hdr_data[63:48] = 16'hA55A;
    end

    always_comb begin
        walk_pos  = int'(k_minus1) % DATA_WIDTH;
        body_data = '0;
        case (mode_q)
            2'd0:    body_data = body_cnt;
            2'd1:    body_data = {REPS{seed_q}};
            2'd2:    body_data = {REPS{lfsr}};
            default: body_data = DATA_WIDTH'(1) << walk_pos;
        endcase
    end

    always_comb begin
        word_ctrl = '0;
        word_data = '0;
        if (state == S_HDR) begin
            word_ctrl = CTRL_SOP;
            word_data = hdr_data;
        end else if (state == S_BODY) begin
            word_ctrl = last_word ? CTRL_EOP : '0;
            word_data = body_data;
`ifdef PKT_GEN_CHECKSUM_EN
            if (last_word) word_data = csum;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_HDR;
            S_HDR:  if (strm.out_rdy) state_nxt = S_BODY;
            S_BODY: begin
                if (strm.out_rdy && last_word) begin
                    if (stop_any || run_full) state_nxt = S_DONE;
                    else if (gap_q != '0)     state_nxt = S_GAP;
                    else                      state_nxt = S_HDR;
                end
            end
            S_GAP: begin
                if (stop_any)                          state_nxt = S_DONE;
                else if (gap_cnt == GAP_WIDTH'(1))     state_nxt = S_HDR;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strm.out_wr   <= 1'b0;
            strm.out_ctrl <= '0;
            strm.out_data <= '0;
            pkt_count     <= '0;
            len_q         <= '0;
            num_q         <= '0;
            gap_q         <= '0;
            mode_q        <= '0;
            seed_q        <= '0;
            lfsr          <= '0;
            body_cnt      <= '0;
            word_k        <= '0;
            gap_cnt       <= '0;
            stop_seen     <= 1'b0;
        end else begin
            strm.out_wr   <= emit_any;
            strm.out_ctrl <= emit_any ? word_ctrl : '0;
            strm.out_data <= emit_any ? word_data : '0;

            if (state == S_IDLE) begin
                stop_seen <= 1'b0;
                if (start) begin
                    len_q     <= (cfg_len < LEN_WIDTH'(2)) ? LEN_WIDTH'(2) : cfg_len;
                    num_q     <= cfg_num_pkts;
                    gap_q     <= cfg_gap;
                    mode_q    <= cfg_mode;
                    seed_q    <= cfg_seed;
                    lfsr      <= (cfg_seed == 32'h0) ? 32'h1 : cfg_seed;
                    body_cnt  <= '0;
                    pkt_count <= '0;
                end
            end else if (busy) begin
                stop_seen <= stop_seen | stop;
            end

            if (emit_hdr) word_k <= LEN_WIDTH'(1);
            if (emit_body) begin
                word_k <= word_k + LEN_WIDTH'(1);
                if (last_word) pkt_count <= pkt_count_inc;
            end
            if (adv_payload) begin
                body_cnt <= body_cnt + DATA_WIDTH'(1);
                lfsr     <= lfsr_nxt;
            end

            if (emit_body && last_word) gap_cnt <= gap_q;
            else if (state == S_GAP)    gap_cnt <= gap_cnt - GAP_WIDTH'(1);
        end
    end

`ifdef PKT_GEN_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            csum <= '0;
        else if (emit_hdr)  csum <= hdr_data;
        else if (emit_body) csum <= csum ^ body_data;
    end
`endif
endmodule
